// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - UART receive buffer with per-entry error flags, overrun, trigger and timeout interrupts
module uart_rx_fifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int DW       = 8,
    parameter int TO_TICKS = 640
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [1:0]                 trig,
    input  logic                       baud_pulse,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pe_in,
    input  logic                       fe_in,
    input  logic                       bi_in,
    input  logic                       pop,
    input  logic                       lsr_rd,
    output logic [DW-1:0]              dout,
    output logic                       dout_pe,
    output logic                       dout_fe,
    output logic                       dout_bi,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overrun,
    output logic                       err_in_fifo,
    output logic                       thr_irq,
    output logic                       timeout_irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TO_TICKS + 1);
    localparam int EW = DW + 3;

    // Each entry is {bi, fe, pe, data}
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  err_cnt;
    logic [CW-1:0]  cap;
    logic [CW-1:0]  trig_lvl;
    logic [TW-1:0]  to_cnt;
    logic           en_q;
    logic           flush;
    logic           do_push;
    logic           do_pop;
    logic           ovr_set;
    logic           push_err;
    logic           head_err;

    // Switching between FIFO and 16450 mode discards whatever was buffered
    assign flush    = clr | (en != en_q);
    assign cap      = en ? CW'(DEPTH) : CW'(1);
    assign empty    = (count == '0);
    assign full     = (count == cap);

    // A pop on a full buffer frees the slot the simultaneous push lands in
    assign do_pop   = !flush && pop && !empty;
    assign do_push  = !flush && push && (!full || do_pop);
    assign ovr_set  = !flush && push && full && !do_pop;

    assign head     = mem[rd_ptr];
    assign push_err = pe_in | fe_in | bi_in;
    assign head_err = |head[EW-1:DW];

    assign dout     = empty ? '0 : head[DW-1:0];
    assign dout_pe  = empty ? 1'b0 : head[DW];
    assign dout_fe  = empty ? 1'b0 : head[DW+1];
    assign dout_bi  = empty ? 1'b0 : head[DW+2];

    assign err_in_fifo = (err_cnt != '0);
    assign thr_irq     = (count >= trig_lvl);
    assign timeout_irq = en && !empty && (to_cnt == TW'(TO_TICKS));

    // Trigger level selection; non-FIFO mode interrupts on every character
    always_comb begin
        trig_lvl = CW'(1);
        if (en) begin
            case (trig)
                2'b00:   trig_lvl = CW'(1);
                2'b01:   trig_lvl = CW'(DEPTH / 4);
                2'b10:   trig_lvl = CW'(DEPTH / 2);
                default: trig_lvl = CW'(DEPTH - 2);
            endcase
        end
    end

    // Character storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {bi_in, fe_in, pe_in, din};
        end
    end

    // Pointers, occupancy, error-entry tally and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= en;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            en_q <= en;
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (lsr_rd) begin
                overrun <= 1'b0;
            end
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                err_cnt <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                case ({do_push && push_err, do_pop && head_err})
                    2'b10:   err_cnt <= err_cnt + 1'b1;
                    2'b01:   err_cnt <= err_cnt - 1'b1;
                    default: err_cnt <= err_cnt;
                endcase
            end
        end
    end

    // Idle timer: counts baud ticks since the last receive or read activity
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (push || pop || flush || empty) begin
            to_cnt <= '0;
        end else if (baud_pulse && (to_cnt != TW'(TO_TICKS))) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - self-checking bench for uart_rx_fifo_ctrl
module tb_uart_rx_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [1:0]  trig;
    logic        baud_pulse;
    logic        push;
    logic [7:0]  din;
    logic        pe_in;
    logic        fe_in;
    logic        bi_in;
    logic        pop;
    logic        lsr_rd;
    logic [7:0]  dout;
    logic        dout_pe;
    logic        dout_fe;
    logic        dout_bi;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overrun;
    logic        err_in_fifo;
    logic        thr_irq;
    logic        timeout_irq;

    int checks = 0;
    int errors = 0;
    logic [10:0] sb [$];

    uart_rx_fifo_ctrl #(.DEPTH(16), .DW(8), .TO_TICKS(640)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig),
        .baud_pulse(baud_pulse), .push(push), .din(din),
        .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in),
        .pop(pop), .lsr_rd(lsr_rd),
        .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi),
        .count(count), .empty(empty), .full(full), .overrun(overrun),
        .err_in_fifo(err_in_fifo), .thr_irq(thr_irq), .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic [2:0] flg, input bit accept);
        push  = 1'b1;
        din   = d;
        pe_in = flg[0];
        fe_in = flg[1];
        bi_in = flg[2];
        if (accept) sb.push_back({flg, d});
        cyc();
        push  = 1'b0;
        {bi_in, fe_in, pe_in} = 3'b000;
    endtask

    task automatic rd(input string tag);
        logic [10:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check(tag, {21'd0, dout_bi, dout_fe, dout_pe, dout}, {21'd0, exp});
        end
        pop = 1'b1;
        cyc();
        pop = 1'b0;
    endtask

    task automatic pulses(input int n);
        baud_pulse = 1'b1;
        repeat (n) cyc();
        baud_pulse = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; trig = 2'b00; baud_pulse = 1'b0;
        push = 1'b0; din = '0; pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
        pop = 1'b0; lsr_rd = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_flags", {overrun, err_in_fifo, thr_irq, timeout_irq}, 0);
        check("rst_dout", {dout_bi, dout_fe, dout_pe, dout}, 0);

        // order preservation
        wr(8'h41, 3'b000, 1);
        check("fwft_dout", dout, 8'h41);
        wr(8'h42, 3'b000, 1);
        wr(8'h43, 3'b000, 1);
        check("three_count", count, 3);
        repeat (3) rd("order");
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        pop = 1'b1; cyc(); pop = 1'b0;
        check("pop_empty_count", count, 0);

        // trigger level 4
        trig = 2'b01;
        for (int i = 0; i < 3; i++) wr(8'h60 + 8'(i), 3'b000, 1);
        check("thr_below", thr_irq, 0);
        wr(8'h63, 3'b000, 1);
        check("thr_at", thr_irq, 1);
        rd("thr_pop");
        check("thr_after_pop", thr_irq, 0);
        repeat (3) rd("thr_drain");

        // overrun at full
        for (int i = 0; i < 16; i++) wr(8'(i), 3'b000, 1);
        check("full_set", full, 1);
        wr(8'h99, 3'b000, 0);
        check("ovr_set", overrun, 1);
        check("ovr_count", count, 16);
        lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
        check("ovr_clear", overrun, 0);
        check("full_pp_dout", dout, sb[0][7:0]);
        void'(sb.pop_front());
        sb.push_back({3'b000, 8'hAA});
        push = 1'b1; din = 8'hAA; pop = 1'b1;
        cyc();
        push = 1'b0; pop = 1'b0;
        check("full_pp_ovr", overrun, 0);
        check("full_pp_count", count, 16);
        repeat (16) rd("full_drain");
        check("full_drain_empty", empty, 1);

        // per-entry error flags
        wr(8'h10, 3'b010, 1);
        wr(8'h20, 3'b000, 1);
        check("err_set", err_in_fifo, 1);
        check("err_head_fe", dout_fe, 1);
        rd("err_pop");
        check("err_clear", err_in_fifo, 0);
        check("err_next", dout, 8'h20);
        rd("err_drain");

        // character timeout
        wr(8'h77, 3'b000, 1);
        pulses(639);
        check("to_639", timeout_irq, 0);
        pulses(1);
        check("to_640", timeout_irq, 1);
        rd("to_pop");
        check("to_pop_irq", timeout_irq, 0);
        wr(8'h78, 3'b000, 1);
        pulses(638);
        baud_pulse = 1'b1;
        wr(8'h79, 3'b000, 1);
        pulses(1);
        check("to_restart", timeout_irq, 0);
        pulses(638);
        check("to_restart_639", timeout_irq, 0);
        pulses(1);
        check("to_restart_640", timeout_irq, 1);
        rd("to_drain");
        check("to_drain_irq", timeout_irq, 0);
        rd("to_drain");

        // 16450 mode
        en = 1'b0;
        cyc();
        wr(8'h55, 3'b000, 1);
        check("m0_full", full, 1);
        check("m0_thr", thr_irq, 1);
        wr(8'h66, 3'b000, 0);
        check("m0_ovr", overrun, 1);
        check("m0_dout", dout, 8'h55);
        en = 1'b1;
        cyc();
        sb.delete();
        check("m0_flush_empty", empty, 1);
        check("m0_flush_ovr", overrun, 1);
        wr(8'h01, 3'b100, 1);
        wr(8'h02, 3'b000, 1);
        clr = 1'b1; cyc(); clr = 1'b0;
        sb.delete();
        check("clr_count", count, 0);
        check("clr_err", err_in_fifo, 0);
        check("clr_ovr_kept", overrun, 1);
        lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
        check("final_ovr", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
